// File: rtl/beta_ifetch_pkg.sv
// Shared definitions for the Beta instruction-fetch stage: instruction field
// positions, the architectural trap vectors and the fetch state encoding.
package beta_ifetch_pkg;

  localparam int OP_HI  = 31;
  localparam int OP_LO  = 26;
  localparam int RC_HI  = 25;
  localparam int RC_LO  = 21;
  localparam int RA_HI  = 20;
  localparam int RA_LO  = 16;
  localparam int RB_HI  = 15;
  localparam int RB_LO  = 11;
  localparam int LIT_HI = 15;
  localparam int LIT_LO = 0;

  localparam logic [31:0] RESET_VEC = 32'h8000_0000;
  localparam logic [31:0] ILLOP_VEC = 32'h8000_0004;
  localparam logic [31:0] XADR_VEC  = 32'h8000_0008;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

  // Memory is word addressed: the supervisor bit and the byte offset are dropped.
  function automatic logic [31:0] imem_addr_of(input logic [31:0] pc);
    return {1'b0, pc[30:2], 2'b00};
  endfunction

endpackage

// File: rtl/beta_ifetch_if.sv
// Bundle of the fetch stage's PC, instruction-memory and decode-side signals.
// The master modport is the fetch stage; the slave modport is its environment.
interface beta_ifetch_if;

  logic [31:0] pc;
  logic        pc_en;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        dec_ready;
  logic        inst_valid;
  logic [31:0] inst;
  logic [5:0]  opcode;
  logic [4:0]  rc;
  logic [4:0]  ra;
  logic [4:0]  rb;
  logic [15:0] id;
  logic        super_mode;
  logic        fetch_fault;

  modport master (
    input  pc, imem_ack, imem_rdata, dec_ready,
    output pc_en, imem_addr, imem_req, inst_valid, inst,
           opcode, rc, ra, rb, id, super_mode, fetch_fault
  );

  modport slave (
    output pc, imem_ack, imem_rdata, dec_ready,
    input  pc_en, imem_addr, imem_req, inst_valid, inst,
           opcode, rc, ra, rb, id, super_mode, fetch_fault
  );

endinterface

// File: rtl/beta_ifetch_timer.sv
// Bounded-wait counter for an outstanding fetch. Expires on the cycle the
// count reaches TIMEOUT_CYCLES-1; a zero limit disables expiry entirely.
module beta_ifetch_timer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  logic [W-1:0] count;

  // Count wait cycles; clear has priority so a new request always starts at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + W'(1);
    end
  end

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_timeout_on
      assign expire = enable && (count == W'(TIMEOUT_CYCLES - 1));
    end else begin : g_timeout_off
      assign expire = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/beta_ifetch.sv
// Beta instruction-fetch stage: requests the word at the current PC, latches
// it (or an illegal-op word on timeout), holds it for decode and pulses pc_en
// once per instruction when decode accepts it.
module beta_ifetch
  import beta_ifetch_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 16,
  parameter logic [31:0] ILLOP_WORD     = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  beta_ifetch_if.master bus
);

  fetch_state_t state;
  logic [31:0]  inst_q;
  logic         super_q;
  logic         valid_q;
  logic         fault_q;
  logic         req_q;
  logic         in_req;
  logic         expire;

  assign in_req = (state == REQ);

  beta_ifetch_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (!in_req || bus.imem_ack),
    .enable(in_req),
    .expire(expire)
  );

  // Fetch sequencing with registered request/valid/fault; ack beats expiry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      inst_q  <= '0;
      super_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state <= REQ;
          req_q <= 1'b1;
        end
        REQ: begin
          if (bus.imem_ack) begin
            inst_q  <= bus.imem_rdata;
            super_q <= bus.pc[31];
            fault_q <= 1'b0;
            valid_q <= 1'b1;
            req_q   <= 1'b0;
            state   <= HOLD;
          end else if (expire) begin
            inst_q  <= ILLOP_WORD;
            super_q <= bus.pc[31];
            fault_q <= 1'b1;
            valid_q <= 1'b1;
            req_q   <= 1'b0;
            state   <= HOLD;
          end
        end
        HOLD: begin
          if (bus.dec_ready) begin
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            req_q   <= 1'b1;
            state   <= REQ;
          end
        end
        default: begin
          state   <= IDLE;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
          fault_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pc_en       = (state == HOLD) && bus.dec_ready;
  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = imem_addr_of(bus.pc);
  assign bus.inst_valid  = valid_q;
  assign bus.fetch_fault = fault_q;
  assign bus.super_mode  = super_q;
  assign bus.inst        = inst_q;
  assign bus.opcode      = inst_q[OP_HI:OP_LO];
  assign bus.rc          = inst_q[RC_HI:RC_LO];
  assign bus.ra          = inst_q[RA_HI:RA_LO];
  assign bus.rb          = inst_q[RB_HI:RB_LO];
  assign bus.id          = inst_q[LIT_HI:LIT_LO];

endmodule
